// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth helper and the status bundle read by the I2C status register.
package fifo_pkg;

    // Number of entries addressed by an ASIZE-bit index.
    function automatic int unsigned fifo_depth(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_thresh_if.sv
// Write/read/status bundle of the threshold FIFO; slave is the FIFO side, master the user side.
interface sync_fifo_thresh_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
);
    logic             flush;
    logic             wr_en;
    logic [DSIZE-1:0] wr_data;
    logic             wr_full;
    logic             wr_almost_full;
    logic             rd_en;
    logic [DSIZE-1:0] rd_data;
    logic             rd_valid;
    logic             rd_empty;
    logic             rd_almost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  wr_full, wr_almost_full, rd_data, rd_valid, rd_empty, rd_almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output wr_full, wr_almost_full, rd_data, rd_valid, rd_empty, rd_almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DSIZE storage: one synchronous write port, one asynchronous read port, reset to zero.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);
    localparam int unsigned DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem_q [DEPTH];

    // Store on write enable; whole array clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags,
// synchronous flush and a build-time choice of fall-through or registered read.
module sync_fifo_thresh
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned ASIZE    = 4,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 4,
    parameter bit          FWFT     = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    sync_fifo_thresh_if.slave bus
);
    localparam logic [ASIZE:0] AfLevel = AF_LEVEL[ASIZE:0];
    localparam logic [ASIZE:0] AeLevel = AE_LEVEL[ASIZE:0];
    localparam logic [ASIZE:0] PtrInc  = {{ASIZE{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [ASIZE:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic             full, empty, wr_accept, rd_accept;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [DSIZE-1:0] ram_rdata;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ASIZE] != rd_ptr_q[ASIZE]) &&
                   (wr_ptr_q[ASIZE-1:0] == rd_ptr_q[ASIZE-1:0]);

    // Acceptance uses pre-edge flags only, so a full FIFO never writes through a same-cycle read.
    assign wr_accept = bus.wr_en & ~full & ~bus.flush;
    assign rd_accept = bus.rd_en & ~empty & ~bus.flush;

    // Pointer and sticky-flag next state; flush overrides requests and suppresses errors.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q & ~bus.clr_err;
        udf_d    = udf_q & ~bus.clr_err;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + PtrInc;
            if (rd_accept) rd_ptr_d = rd_ptr_q + PtrInc;
            // Setting after the clear makes set win over clr_err.
            if (bus.wr_en && full)  ovf_d = 1'b1;
            if (bus.rd_en && empty) udf_d = 1'b1;
        end
    end

    // Pointer and sticky-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q[ASIZE-1:0]),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q[ASIZE-1:0]),
        .rdata_o (ram_rdata)
    );

    assign bus.wr_full         = full;
    assign bus.wr_almost_full  = (count >= AfLevel);
    assign bus.rd_empty        = empty;
    assign bus.rd_almost_empty = (count <= AeLevel);
    assign bus.count           = count;
    assign bus.overflow        = ovf_q;
    assign bus.underflow       = udf_q;

    if (FWFT) begin : g_fwft
        // Head of queue is always on display; rd_en pops it.
        assign bus.rd_data  = ram_rdata;
        assign bus.rd_valid = ~empty;
    end else begin : g_reg
        logic [DSIZE-1:0] rd_data_q;
        logic             rd_valid_q;

        // Capture head on an accepted read; valid pulses for one cycle, data holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_accept;
                if (rd_accept) rd_data_q <= ram_rdata;
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end
endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Bench: fall-through and registered-read instances share stimulus and one queue model.
module tb_sync_fifo_thresh;
    logic       clk, rst_n;
    logic       flush, wr_en, rd_en, clr_err;
    logic [7:0] wr_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents as a queue, plus sticky flags and registered-read output.
    logic [7:0] mq[$];
    logic       m_ovf, m_udf, m_valid_b;
    logic [7:0] m_data_b;

    sync_fifo_thresh_if #(.DSIZE(8), .ASIZE(4)) bus_a ();
    sync_fifo_thresh_if #(.DSIZE(8), .ASIZE(4)) bus_b ();

    assign bus_a.flush   = flush;
    assign bus_a.wr_en   = wr_en;
    assign bus_a.wr_data = wr_data;
    assign bus_a.rd_en   = rd_en;
    assign bus_a.clr_err = clr_err;
    assign bus_b.flush   = flush;
    assign bus_b.wr_en   = wr_en;
    assign bus_b.wr_data = wr_data;
    assign bus_b.rd_en   = rd_en;
    assign bus_b.clr_err = clr_err;

    sync_fifo_thresh #(
        .DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b1)
    ) u_dut_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    sync_fifo_thresh #(
        .DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b0)
    ) u_dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr, rd, clr;
        logic [7:0] data;
        int         cnt;
        logic       af, full, ae, empty, ovf, udf;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(input logic wr, input logic rd, input logic clr,
                                input logic [7:0] d, input int cnt,
                                input logic ovf, input logic udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.data = d; v.cnt = cnt;
        v.af = (cnt >= 12); v.full = (cnt == 16); v.ae = (cnt <= 4); v.empty = (cnt == 0);
        v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_valid_b = 1'b0; m_data_b = 8'h00;
    endtask

    task automatic model_edge();
        logic pre_full, pre_empty;
        pre_full  = (mq.size() == 16);
        pre_empty = (mq.size() == 0);
        if (clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
        m_valid_b = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            if (wr_en && pre_full)  m_ovf = 1'b1;
            if (rd_en && pre_empty) m_udf = 1'b1;
            if (rd_en && !pre_empty) begin
                m_data_b  = mq.pop_front();
                m_valid_b = 1'b1;
            end
            if (wr_en && !pre_full) mq.push_back(wr_data);
        end
    endtask

    task automatic chk_flags(input string p, input logic [4:0] cnt, input logic f,
                             input logic af, input logic e, input logic ae,
                             input logic o, input logic u);
        int n;
        n = mq.size();
        chk({p, "_count"}, 32'(cnt), 32'(n));
        chk({p, "_full"}, 32'(f), 32'(n == 16));
        chk({p, "_almost_full"}, 32'(af), 32'(n >= 12));
        chk({p, "_empty"}, 32'(e), 32'(n == 0));
        chk({p, "_almost_empty"}, 32'(ae), 32'(n <= 4));
        chk({p, "_overflow"}, 32'(o), 32'(m_ovf));
        chk({p, "_underflow"}, 32'(u), 32'(m_udf));
    endtask

    task automatic check_model();
        chk_flags("a", bus_a.count, bus_a.wr_full, bus_a.wr_almost_full, bus_a.rd_empty,
                  bus_a.rd_almost_empty, bus_a.overflow, bus_a.underflow);
        chk_flags("b", bus_b.count, bus_b.wr_full, bus_b.wr_almost_full, bus_b.rd_empty,
                  bus_b.rd_almost_empty, bus_b.overflow, bus_b.underflow);
        chk("a_rd_valid", 32'(bus_a.rd_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("a_rd_data", 32'(bus_a.rd_data), 32'(mq[0]));
        chk("b_rd_valid", 32'(bus_b.rd_valid), 32'(m_valid_b));
        chk("b_rd_data", 32'(bus_b.rd_data), 32'(m_data_b));
    endtask

    task automatic check_reset();
        chk("rst_a_count", 32'(bus_a.count), 0);
        chk("rst_b_count", 32'(bus_b.count), 0);
        chk("rst_a_full", 32'(bus_a.wr_full), 0);
        chk("rst_a_almost_full", 32'(bus_a.wr_almost_full), 0);
        chk("rst_a_empty", 32'(bus_a.rd_empty), 1);
        chk("rst_a_almost_empty", 32'(bus_a.rd_almost_empty), 1);
        chk("rst_a_rd_valid", 32'(bus_a.rd_valid), 0);
        chk("rst_a_rd_data", 32'(bus_a.rd_data), 0);
        chk("rst_b_rd_valid", 32'(bus_b.rd_valid), 0);
        chk("rst_b_rd_data", 32'(bus_b.rd_data), 0);
        chk("rst_a_overflow", 32'(bus_a.overflow), 0);
        chk("rst_a_underflow", 32'(bus_a.underflow), 0);
        chk("rst_b_overflow", 32'(bus_b.overflow), 0);
        chk("rst_b_underflow", 32'(bus_b.underflow), 0);
    endtask

    // One clock: drive away from the edge, update model at the edge, check just after.
    task automatic step(input logic fl, input logic wr, input logic rd, input logic clr,
                        input logic [7:0] d);
        @(negedge clk);
        flush = fl; wr_en = wr; rd_en = rd; clr_err = clr; wr_data = d;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        flush = 0; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = 0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_reset();
        @(negedge clk) rst_n = 1'b1;

        // Fill with 0x00..0x0F, overflow on 17th, drain, underflow, clear.
        for (int i = 0; i < 16; i++) vecs[i] = mk(1, 0, 0, 8'(i), i + 1, 0, 0);
        vecs[16] = mk(1, 0, 0, 8'hAA, 16, 1, 0);
        for (int i = 0; i < 16; i++) vecs[17 + i] = mk(0, 1, 0, 8'h00, 15 - i, 1, 0);
        vecs[33] = mk(0, 1, 0, 8'h00, 0, 1, 1);
        vecs[34] = mk(0, 0, 1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 35; i++) begin
            step(0, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].data);
            chk("vec_count", 32'(bus_a.count), 32'(vecs[i].cnt));
            chk("vec_almost_full", 32'(bus_a.wr_almost_full), 32'(vecs[i].af));
            chk("vec_full", 32'(bus_a.wr_full), 32'(vecs[i].full));
            chk("vec_almost_empty", 32'(bus_a.rd_almost_empty), 32'(vecs[i].ae));
            chk("vec_empty", 32'(bus_a.rd_empty), 32'(vecs[i].empty));
            chk("vec_overflow", 32'(bus_a.overflow), 32'(vecs[i].ovf));
            chk("vec_underflow", 32'(bus_a.underflow), 32'(vecs[i].udf));
            if (i >= 17 && i < 33) chk("vec_pop_data", 32'(bus_b.rd_data), 32'(i - 17));
        end

        // Sustained write+read at count 3 across pointer wrap.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h30 + 8'(i));
        for (int i = 0; i < 40; i++) step(0, 1, 1, 0, 8'h40 + 8'(i));
        chk("wrap_count", 32'(bus_a.count), 3);
        chk("wrap_overflow", 32'(bus_a.overflow), 0);
        chk("wrap_underflow", 32'(bus_a.underflow), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00);

        // Full with both requests: read takes head, write rejected.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h80 + 8'(i));
        step(0, 1, 1, 0, 8'hEE);
        chk("fullboth_count", 32'(bus_a.count), 15);
        chk("fullboth_overflow", 32'(bus_a.overflow), 1);
        chk("fullboth_head", 32'(bus_b.rd_data), 32'h80);
        step(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 8'h00);

        // Empty with both requests: write stored, read flags underflow.
        step(0, 1, 1, 0, 8'h3C);
        chk("emptyboth_count", 32'(bus_a.count), 1);
        chk("emptyboth_underflow", 32'(bus_a.underflow), 1);
        chk("emptyboth_data", 32'(bus_a.rd_data), 32'h3C);

        // Flush at count 7 with a write in the same cycle.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 8'h60 + 8'(i));
        chk("preflush_count", 32'(bus_a.count), 7);
        step(1, 1, 0, 0, 8'h99);
        chk("flush_count", 32'(bus_a.count), 0);
        chk("flush_empty", 32'(bus_a.rd_empty), 1);
        chk("flush_underflow_kept", 32'(bus_a.underflow), 1);
        chk("flush_overflow_kept", 32'(bus_a.overflow), 0);
        step(0, 0, 0, 1, 8'h00);

        // Registered read: write 0x5A, read next cycle, valid pulses once and data holds.
        step(0, 1, 0, 0, 8'h5A);
        chk("lat_b_valid_early", 32'(bus_b.rd_valid), 0);
        chk("lat_a_data", 32'(bus_a.rd_data), 32'h5A);
        step(0, 0, 1, 0, 8'h00);
        chk("lat_b_data", 32'(bus_b.rd_data), 32'h5A);
        chk("lat_b_valid", 32'(bus_b.rd_valid), 1);
        step(0, 0, 0, 0, 8'h00);
        chk("lat_b_valid_pulse", 32'(bus_b.rd_valid), 0);
        chk("lat_b_data_hold", 32'(bus_b.rd_data), 32'h5A);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 5), 8'($urandom));
        end

        // Reset asserted mid-burst with contents and a sticky flag present.
        step(1, 0, 0, 1, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'hC0 + 8'(i));
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hD5;
        #2 rst_n = 1'b0;
        #1 check_reset();
        model_reset();
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
